// File: rtl/ldl_fifo_pkg.sv
// ldl_fifo_pkg: helpers shared by the write-side and read-side LDL FIFO controllers
package ldl_fifo_pkg;
  typedef logic [31:0] ptr_raw_t;
  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction
  function automatic ptr_raw_t ptr_cnt(input ptr_raw_t w, input ptr_raw_t r);
    return w - r;
  endfunction
endpackage

// File: rtl/ldl_fifo_ws_v1_if.sv
// ldl_fifo_ws_v1_if: write-side controller signals between the user/read side and the controller
interface ldl_fifo_ws_v1_if #(parameter int AW = 8);
  logic we, full, almost_full, mw, overflow, clr_stat;
  logic [AW-1:0] wa;
  logic [AW:0] w_pt, r_pt, wcnt, max_cnt;
  modport master(output we, r_pt, clr_stat, input full, almost_full, wa, mw, w_pt, wcnt, overflow, max_cnt);
  modport slave(input we, r_pt, clr_stat, output full, almost_full, wa, mw, w_pt, wcnt, overflow, max_cnt);
endinterface

// File: rtl/ldl_fifo_wstat.sv
// ldl_fifo_wstat: sticky overflow flag and occupancy high-watermark for debug readback
module ldl_fifo_wstat #(parameter int W = 9) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic         full,
  input  logic         clr_stat,
  input  logic [W-1:0] ncnt,
  output logic         overflow,
  output logic [W-1:0] max_cnt
);
  // a new overflow beats a concurrent clear; clear reloads the watermark with the live count
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      max_cnt  <= '0;
    end else begin
      overflow <= (we & full) | (overflow & ~clr_stat);
      max_cnt  <= (clr_stat || ncnt > max_cnt) ? ncnt : max_cnt;
    end
  end
endmodule

// File: rtl/ldl_fifo_ws_v1.sv
// ldl_fifo_ws_v1: write pointer, full/almost-full flags and RAM write port of the LDL FIFO
module ldl_fifo_ws_v1
  import ldl_fifo_pkg::*;
#(
  parameter int AW       = 8,
  parameter int AF_LEVEL = 2**AW - 2
) (
  input logic           clk,
  input logic           rst,
  ldl_fifo_ws_v1_if.slave bus
);
  typedef logic [AW:0] ptr_t;
  localparam ptr_t DEPTH = ptr_t'(depth(AW));
  localparam ptr_t AF    = ptr_t'(AF_LEVEL);
  ptr_t w_pt, wcnt, ncnt;
  logic full, almost_full, fw;
  // accepted write and occupancy; the read pointer is same-domain so it is used directly
  always_comb begin
    fw   = bus.we & ~full & ~rst;
    wcnt = ptr_t'(ptr_cnt(32'(w_pt), 32'(bus.r_pt)));
    ncnt = wcnt + ptr_t'(fw);
  end
  // full ignores same-cycle reads, so it may linger one cycle but can never let the RAM overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      w_pt        <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      w_pt        <= w_pt + ptr_t'(fw);
      full        <= (wcnt == DEPTH) || (wcnt == DEPTH - 1'b1 && fw);
      almost_full <= ncnt >= AF;
    end
  end
  ldl_fifo_wstat #(.W(AW + 1)) u_stat (
    .clk(clk),
    .rst(rst),
    .we(bus.we),
    .full(full),
    .clr_stat(bus.clr_stat),
    .ncnt(ncnt),
    .overflow(bus.overflow),
    .max_cnt(bus.max_cnt)
  );
  assign bus.full        = full;
  assign bus.almost_full = almost_full;
  assign bus.mw          = fw;
  assign bus.wa          = w_pt[AW-1:0];
  assign bus.w_pt        = w_pt;
  assign bus.wcnt        = wcnt;
endmodule

// File: tb/tb_ldl_fifo_ws_v1.sv
// tb_ldl_fifo_ws_v1: scoreboard bench for the LDL FIFO write-side controller
module tb_ldl_fifo_ws_v1;
  localparam int AW = 3;
  localparam int AF = 6;
  localparam int D  = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ldl_fifo_ws_v1_if #(.AW(AW)) bus();
  ldl_fifo_ws_v1 #(.AW(AW), .AF_LEVEL(AF)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {
    bit skip;
    bit mw;
    bit full;
    bit af;
    bit ovf;
    int wcnt;
    int w_pt;
    int max_cnt;
  } exp_t;
  exp_t sq[$];
  int   wq[$];
  int total = 0, bad = 0;
  int m_w = 0, m_r = 0, m_max = 0;
  bit m_full = 0, m_af = 0, m_ovf = 0, primed = 0, done = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", n, $time, a, x);
    end
  endtask

  // one clock of stimulus; the model tracks true occupancy as total writes minus total reads
  task automatic cyc(input bit we, input bit rd, input bit clr, input bit rs);
    exp_t e;
    int occ, ncnt;
    bit fw;
    @(negedge clk);
    occ = m_w - m_r;
    rst = rs;
    bus.we = we;
    bus.clr_stat = clr;
    bus.r_pt = 4'(m_r % 16);
    fw = we && !m_full && !rs;
    e.skip = !primed;
    e.mw = fw;
    e.full = m_full;
    e.af = m_af;
    e.ovf = m_ovf;
    e.wcnt = occ;
    e.w_pt = m_w % 16;
    e.max_cnt = m_max;
    sq.push_back(e);
    if (fw) wq.push_back(m_w % D);
    if (rs) begin
      m_w = 0; m_r = 0; m_max = 0;
      m_full = 0; m_af = 0; m_ovf = 0;
      primed = 1;
    end else begin
      ncnt = occ + (fw ? 1 : 0);
      m_ovf = (we && m_full) || (m_ovf && !clr);
      m_full = (occ == D) || (occ == D - 1 && fw);
      m_af = ncnt >= AF;
      m_max = (clr || ncnt > m_max) ? ncnt : m_max;
      if (fw) m_w++;
      if (rd && occ > 0) m_r++;
    end
  endtask

  task automatic drive();
    int pw, pr;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    repeat (8) cyc(1, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    repeat (8) cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (20) cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (2) cyc(0, 1, 0, 0);
    repeat (5) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    for (int p = 0; p < 30; p++) begin
      pw = $urandom_range(10, 95);
      pr = $urandom_range(10, 95);
      repeat (100) cyc($urandom_range(99) < pw, $urandom_range(99) < pr,
                       $urandom_range(49) == 0, $urandom_range(399) == 0);
    end
    cyc(0, 0, 0, 0);
  endtask

  // monitor: pops one expectation per cycle, and one expected address per observed RAM write
  task automatic mon();
    exp_t e;
    for (;;) begin
      @(negedge clk);
      #2;
      if (sq.size() == 0) begin
        if (done) break;
        continue;
      end
      e = sq.pop_front();
      if (e.skip) continue;
      chk("mw", 32'(bus.mw), 32'(e.mw));
      chk("wcnt", 32'(bus.wcnt), 32'(e.wcnt));
      chk("w_pt", 32'(bus.w_pt), 32'(e.w_pt));
      chk("full", 32'(bus.full), 32'(e.full));
      chk("almost_full", 32'(bus.almost_full), 32'(e.af));
      chk("overflow", 32'(bus.overflow), 32'(e.ovf));
      chk("max_cnt", 32'(bus.max_cnt), 32'(e.max_cnt));
      if (bus.mw === 1'b1) begin
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wa_unexpected_write t=%0t got=%0d want=none", $time, bus.wa);
        end else chk("wa", 32'(bus.wa), 32'(wq.pop_front()));
      end
    end
  endtask

  initial begin
    bus.we = 1'b0;
    bus.clr_stat = 1'b0;
    bus.r_pt = '0;
    fork
      mon();
      begin
        drive();
        done = 1;
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ldl_fifo_ws_v1.md
Name: ldl_fifo_ws_v1

Overview:
Write-side pointer/flag controller for the synchronous LDL FIFO. It pairs with the read-side controller: it owns the write pointer and the full/almost-full flags, drives the RAM write address/enable, and consumes the read pointer. It also keeps sticky overflow and high-watermark status for debug and CSR readback.

Parameters:
AW, 8, address width; FIFO depth DEPTH = 2**AW entries.
AF_LEVEL, 2**AW - 2, almost_full threshold in entries, legal range 1..2**AW.

Ports:
clk  input  1  clock; all logic rising-edge.
rst  input  1  synchronous reset, active-high.
we  input  1  write request.
full  output  1  registered; FIFO full, writes ignored.
almost_full  output  1  registered; occupancy (incl. this cycle's write) >= AF_LEVEL.
wa  output  AW  RAM write address.
mw  output  1  RAM write enable (accepted write).
w_pt  output  AW+1  write pointer, MSB is wrap bit; to read side.
r_pt  input  AW+1  read pointer from read side.
wcnt  output  AW+1  occupancy seen by writer, w_pt - r_pt modulo 2**(AW+1).
overflow  output  1  sticky: a write was attempted while full.
max_cnt  output  AW+1  high-watermark of occupancy.
clr_stat  input  1  synchronous clear of overflow and max_cnt.

Behaviour:
- Reset (rst=1 at edge): w_pt=0, full=0, almost_full=0, overflow=0, max_cnt=0. we is ignored while rst=1.
- Combinational outputs:
  - fw = we & ~full.
  - mw = fw.
  - wa = w_pt[AW-1:0]. There is no look-ahead: the address is the current slot and data is written in the same cycle.
  - wcnt = w_pt - r_pt, AW+1-bit modulo subtraction, range 0..DEPTH.
- Pointer: on fw, w_pt <= w_pt + 1, wrapping naturally at 2**(AW+1).
- Next-count: ncnt = wcnt + fw, width AW+1, never exceeds DEPTH.
- full, per cycle, first matching rule wins:
  1. wcnt == DEPTH -> full <= 1.
  2. wcnt == DEPTH-1 && fw -> full <= 1.
  3. Otherwise full <= 0.
- full is conservative:
  - A read in the same cycle as the last write still sets full for one cycle.
  - full deasserts one cycle after r_pt advances. This mirrors empty on the read side.
  - Overflow of the RAM is impossible.
- almost_full <= (ncnt >= AF_LEVEL). It deasserts one cycle after the read that drops occupancy below AF_LEVEL.
- overflow:
  - Set when we & full at a clock edge.
  - Cleared by clr_stat.
  - If set and clear occur in the same cycle, set wins.
  - The dropped write does not move w_pt and does not assert mw.
- max_cnt:
  - max_cnt <= ncnt when ncnt > max_cnt.
  - clr_stat loads max_cnt <= ncnt, not 0, so a concurrent write is not lost.
- Simultaneous write and read:
  - Occupancy is unchanged; w_pt and r_pt each advance by one.
  - full keeps the rule above; with wcnt == DEPTH, we is still rejected that cycle.
- Wrap: pointers compare as AW+1-bit values. DEPTH entries means equal low bits and opposite MSB, and wcnt == DEPTH holds correctly across wrap.
- Reset mid-operation:
  - All state returns to reset values the next cycle. mw is 0 during the reset cycle.
  - The read side must be reset together with this block; a skewed reset is not supported.
- r_pt is required to be from the same clock domain, because it is used unsynchronised.

Decomposition:
- Shared package ldl_fifo_pkg:
  - localparam-style function depth(AW).
  - Pointer typedef template as an AW+1 logic vector.
  - Function ptr_cnt(w, r) returning w - r.
  - This package is reused by the read side.
- One natural sub-module, ldl_fifo_wstat: overflow sticky bit plus max_cnt watermark. Inputs are we, full, ncnt, clr_stat, clk, rst.
- Pointer and flag logic stays in the top module.

Test Plan:
1. AW=3, AF_LEVEL=6, reset then 8 back-to-back writes with no reads:
   - mw high for 8 cycles, wa = 0..7.
   - almost_full rises in the cycle after the 6th write.
   - full rises in the cycle after the 8th write; wcnt = 8 and w_pt = 8.
2. From full, hold we=1 for 3 cycles:
   - mw = 0 and w_pt stays 8.
   - overflow = 1 after the first attempt and stays 1.
   - Pulse clr_stat: overflow = 0 and max_cnt = 8.
3. From full, advance r_pt by 1 with we=0:
   - full = 0 one cycle later.
   - Next write accepted at wa = 0, then full = 1 again.
4. wcnt = 7 with write and read in the same cycle:
   - full pulses 1 for exactly one cycle, then returns to 0 with wcnt = 7.
   - A write in the pulse cycle is rejected and sets overflow.
5. Wrap: push and pop 20 entries while keeping occupancy at 2 or less:
   - w_pt MSB toggles at 8 and 16, wcnt always matches the true occupancy, full never asserts, and max_cnt = 2.
6. Assert rst mid-burst with occupancy 5:
   - Next cycle w_pt = 0, full = 0, almost_full = 0, overflow = 0, max_cnt = 0.
   - mw stays 0 while rst is high.
